// File: rtl/pipe_collision_ctrl_pkg.sv
// rtl/pipe_collision_ctrl_pkg.sv - shared game state encoding, screen/bird constants and X clamp helper
package pipe_collision_ctrl_pkg;

  // One-hot game state; the bits drive q_idle/q_play/q_dead directly
  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_PLAY = 3'b010,
    ST_DEAD = 3'b100
  } game_state_t;

  localparam int SCREEN_W     = 640;
  localparam int GROUND_Y_DEF = 460;
  localparam int BIRD_X_L_DEF = 200;
  localparam int BIRD_X_R_DEF = 230;
  localparam int BIRD_H_DEF   = 20;
  localparam int NUM_PIPES    = 5;
  // Each pipe carries one coin, so coin slots track pipe slots
  localparam int NUM_COINS    = NUM_PIPES;

  // Pipe edges beyond the right border act as if sitting on the border
  function automatic logic [10:0] clamp_x(input logic [9:0] x);
    logic [10:0] xe;
    xe = {1'b0, x};
    if (xe > 11'(SCREEN_W)) clamp_x = 11'(SCREEN_W);
    else clamp_x = xe;
  endfunction

endpackage

// File: rtl/pipe_collision_ctrl_box_overlap.sv
// rtl/pipe_collision_ctrl_box_overlap.sv - combinational rectangle intersection test, right/bottom edges exclusive
module pipe_collision_ctrl_box_overlap (
  input  logic [10:0] a_l,
  input  logic [10:0] a_r,
  input  logic [10:0] a_t,
  input  logic [10:0] a_b,
  input  logic [10:0] b_l,
  input  logic [10:0] b_r,
  input  logic [10:0] b_t,
  input  logic [10:0] b_b,
  output logic        hit
);

  // Boxes intersect when they overlap on both axes
  assign hit = (a_l < b_r) && (a_r > b_l) && (a_t < b_b) && (a_b > b_t);

endmodule

// File: rtl/pipe_collision_ctrl.sv
// rtl/pipe_collision_ctrl.sv - collision/coin game control driving the pipe store start/stop/ack handshake; coin logic under COLLISION_COIN_EN
module pipe_collision_ctrl
  import pipe_collision_ctrl_pkg::*;
#(
  parameter int BIRD_X_L   = BIRD_X_L_DEF,
  parameter int BIRD_X_R   = BIRD_X_R_DEF,
  parameter int BIRD_H     = BIRD_H_DEF,
  parameter int GROUND_Y   = GROUND_Y_DEF,
  parameter int HIT_CYCLES = 2,
  parameter int DEAD_HOLD  = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_btn,
  input  logic       flap_btn,
  input  logic [9:0] bird_y,
  input  logic [9:0] pipe_l,
  input  logic [9:0] pipe_r,
  input  logic [9:0] gap_top,
  input  logic [9:0] gap_bot,
  input  logic [9:0] coin_l,
  input  logic [9:0] coin_r,
  input  logic [9:0] coin_top,
  input  logic [9:0] coin_bot,
  input  logic [2:0] coin_idx,
  output logic       start,
  output logic       stop,
  output logic       ack,
  output logic       coin_taken,
  output logic [7:0] coin_count,
  output logic       hit_ground,
  output logic       q_idle,
  output logic       q_play,
  output logic       q_dead
);

  localparam logic [10:0] BX_L   = 11'(BIRD_X_L);
  localparam logic [10:0] BX_R   = 11'(BIRD_X_R);
  localparam logic [10:0] BH     = 11'(BIRD_H);
  localparam logic [10:0] GND    = 11'(GROUND_Y);
  localparam logic [4:0]  HIT_N  = 5'(HIT_CYCLES);
  localparam logic [7:0]  HOLD_N = 8'(DEAD_HOLD);

  game_state_t state;
  logic        start_btn_q;
  logic        flap_btn_q;
  logic [3:0]  ov_cnt;
  logic [7:0]  hold_cnt;
  logic [10:0] bird_top;
  logic [10:0] bird_bot;
  logic [10:0] pipe_l_c;
  logic [10:0] pipe_r_c;
  logic [4:0]  ov_inc;
  logic        start_rise;
  logic        flap_rise;
  logic        pipe_col;
  logic        pipe_ov;
  logic        ground;
  logic        pipe_dead;

  assign bird_top   = {1'b0, bird_y};
  assign bird_bot   = bird_top + BH;
  assign pipe_l_c   = clamp_x(pipe_l);
  assign pipe_r_c   = clamp_x(pipe_r);
  assign start_rise = start_btn & ~start_btn_q;
  assign flap_rise  = flap_btn & ~flap_btn_q;
  assign ground     = bird_bot >= GND;
  // Column spans down to the ground; anything lower is already a ground death
  assign pipe_ov    = pipe_col && ((bird_top < {1'b0, gap_top}) || (bird_bot > {1'b0, gap_bot}));
  assign ov_inc     = {1'b0, ov_cnt} + 5'd1;
  assign pipe_dead  = pipe_ov && (ov_inc >= HIT_N);

  assign {q_dead, q_play, q_idle} = state;

  pipe_collision_ctrl_box_overlap u_pipe_box (
    .a_l (BX_L),
    .a_r (BX_R),
    .a_t (bird_top),
    .a_b (bird_bot),
    .b_l (pipe_l_c),
    .b_r (pipe_r_c),
    .b_t (11'd0),
    .b_b (GND),
    .hit (pipe_col)
  );

  // Game FSM: start/stop/ack handshake, pipe hit confirmation and death hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      start_btn_q <= 1'b0;
      flap_btn_q  <= 1'b0;
      start       <= 1'b0;
      stop        <= 1'b0;
      ack         <= 1'b0;
      hit_ground  <= 1'b0;
      ov_cnt      <= 4'd0;
      hold_cnt    <= 8'd0;
    end else begin
      start_btn_q <= start_btn;
      flap_btn_q  <= flap_btn;
      start       <= 1'b0;
      ack         <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_rise) begin
            start      <= 1'b1;
            ov_cnt     <= 4'd0;
            hit_ground <= 1'b0;
            state      <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (tick) begin
            if (ground) begin
              state      <= ST_DEAD;
              stop       <= 1'b1;
              hit_ground <= 1'b1;
              hold_cnt   <= 8'd0;
            end else if (pipe_dead) begin
              state      <= ST_DEAD;
              stop       <= 1'b1;
              hit_ground <= 1'b0;
              hold_cnt   <= 8'd0;
            end else begin
              ov_cnt <= pipe_ov ? ov_inc[3:0] : 4'd0;
            end
          end
        end
        ST_DEAD: begin
          // Flap edges seen while holding are consumed by the edge detector
          if (hold_cnt < HOLD_N) begin
            if (tick) hold_cnt <= hold_cnt + 8'd1;
          end else if (flap_rise) begin
            ack        <= 1'b1;
            stop       <= 1'b0;
            hit_ground <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef COLLISION_COIN_EN
  logic [NUM_COINS-1:0] taken_mask;
  logic [2:0]           coin_idx_q;
  logic                 coin_box;
  logic                 coin_new;

  pipe_collision_ctrl_box_overlap u_coin_box (
    .a_l (BX_L),
    .a_r (BX_R),
    .a_t (bird_top),
    .a_b (bird_bot),
    .b_l ({1'b0, coin_l}),
    .b_r ({1'b0, coin_r}),
    .b_t ({1'b0, coin_top}),
    .b_b ({1'b0, coin_bot}),
    .hit (coin_box)
  );

  assign coin_new = coin_box && (coin_idx < 3'(NUM_COINS)) && !taken_mask[coin_idx];

  // Coin pickup bookkeeping; a tick that kills the bird never scores
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_mask <= '0;
      coin_idx_q <= 3'd0;
      coin_taken <= 1'b0;
      coin_count <= 8'd0;
    end else begin
      coin_taken <= 1'b0;
      coin_idx_q <= coin_idx;
      if (state == ST_IDLE && start_rise) begin
        taken_mask <= '0;
        coin_count <= 8'd0;
      end else if (state == ST_PLAY) begin
        // A recycled coin slot becomes collectable again once the store moves on
        if (coin_idx != coin_idx_q && coin_idx_q < 3'(NUM_COINS))
          taken_mask[coin_idx_q] <= 1'b0;
        if (tick && !ground && !pipe_dead && coin_new) begin
          taken_mask[coin_idx] <= 1'b1;
          coin_taken           <= 1'b1;
          if (coin_count != 8'hFF) coin_count <= coin_count + 8'd1;
        end
      end
    end
  end
`else
  logic unused_coin;
  assign unused_coin = ^{coin_l, coin_r, coin_top, coin_bot, coin_idx};
  assign coin_taken  = 1'b0;
  assign coin_count  = 8'd0;
`endif

endmodule

// File: tb/tb_pipe_collision_ctrl.sv
// tb/tb_pipe_collision_ctrl.sv - randomized self-checking bench for pipe_collision_ctrl
module tb_pipe_collision_ctrl;

  localparam int HIT  = 2;
  localparam int HOLD = 60;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       flap_btn = 1'b0;
  logic [9:0] bird_y, pipe_l, pipe_r, gap_top, gap_bot;
  logic [9:0] coin_l, coin_r, coin_top, coin_bot;
  logic [2:0] coin_idx;
  logic       start, stop, ack, coin_taken, hit_ground, q_idle, q_play, q_dead;
  logic [7:0] coin_count;

  int checks = 0;
  int failures = 0;

  pipe_collision_ctrl dut (
    .clk(clk), .reset(reset), .tick(tick), .start_btn(start_btn), .flap_btn(flap_btn),
    .bird_y(bird_y), .pipe_l(pipe_l), .pipe_r(pipe_r), .gap_top(gap_top), .gap_bot(gap_bot),
    .coin_l(coin_l), .coin_r(coin_r), .coin_top(coin_top), .coin_bot(coin_bot),
    .coin_idx(coin_idx), .start(start), .stop(stop), .ack(ack), .coin_taken(coin_taken),
    .coin_count(coin_count), .hit_ground(hit_ground),
    .q_idle(q_idle), .q_play(q_play), .q_dead(q_dead)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic safe_inputs();
    bird_y = 10'd200; pipe_l = 10'd500; pipe_r = 10'd560; gap_top = 10'd100; gap_bot = 10'd300;
    coin_l = 10'd600; coin_r = 10'd620; coin_top = 10'd0; coin_bot = 10'd10; coin_idx = 3'd0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    safe_inputs();
    @(negedge clk);
  endtask

  task automatic begin_game();
    start_btn = 1'b1;
    @(negedge clk);
    checks++; if (start !== 1'b1) begin failures++; $display("FAIL start_pulse: got %b expected 1", start); end
    checks++; if (q_play !== 1'b1) begin failures++; $display("FAIL enter_play: got %b expected 1", q_play); end
    checks++; if (coin_count !== 8'd0) begin failures++; $display("FAIL start_count: got %0d expected 0", coin_count); end
    start_btn = 1'b0;
    @(negedge clk);
    checks++; if (start !== 1'b0) begin failures++; $display("FAIL start_width: got %b expected 0", start); end
  endtask

  task automatic finish_dead();
    repeat (HOLD) do_tick();
    flap_btn = 1'b1;
    @(negedge clk);
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL ack_pulse: got %b expected 1", ack); end
    checks++; if (q_idle !== 1'b1 || stop !== 1'b0) begin failures++; $display("FAIL ack_idle: q_idle=%b stop=%b expected 1/0", q_idle, stop); end
    flap_btn = 1'b0;
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL ack_width: got %b expected 0", ack); end
  endtask

  task automatic test_reset();
    safe_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({q_idle, q_play, q_dead} !== 3'b100 || {start, stop, ack, coin_taken, hit_ground} !== 5'b0 || coin_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_state: q=%b%b%b outs=%b%b%b%b%b count=%0d expected q=100 outs=0 count=0",
               q_idle, q_play, q_dead, start, stop, ack, coin_taken, hit_ground, coin_count);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start();
    begin_game();
    start_btn = 1'b1;
    @(negedge clk);
    checks++; if (start !== 1'b0 || q_play !== 1'b1) begin failures++; $display("FAIL start_in_play: start=%b q_play=%b expected 0/1", start, q_play); end
    start_btn = 1'b0;
    pulse_reset();
  endtask

  task automatic test_pipe_hit();
    begin_game();
    bird_y = 10'd100; gap_top = 10'd150; gap_bot = 10'd250; pipe_l = 10'd220; pipe_r = 10'd281;
    repeat (3) @(negedge clk);
    checks++; if (q_play !== 1'b1) begin failures++; $display("FAIL no_tick_eval: q_play=%b expected 1", q_play); end
    do_tick();
    pipe_l = 10'd500; pipe_r = 10'd560;
    do_tick();
    pipe_l = 10'd220; pipe_r = 10'd281;
    do_tick();
    checks++; if (stop !== 1'b0 || q_play !== 1'b1) begin failures++; $display("FAIL overlap_reset: stop=%b q_play=%b expected 0/1", stop, q_play); end
    @(negedge clk);
    do_tick();
    checks++; if (stop !== 1'b1 || q_dead !== 1'b1) begin failures++; $display("FAIL pipe_hit: stop=%b q_dead=%b expected 1/1", stop, q_dead); end
    checks++; if (hit_ground !== 1'b0) begin failures++; $display("FAIL pipe_cause: hit_ground=%b expected 0", hit_ground); end
    safe_inputs();
    finish_dead();
  endtask

  task automatic test_ground_and_ack();
    bit ack_seen;
    begin_game();
    bird_y = 10'd439; gap_top = 10'd150; gap_bot = 10'd250; pipe_l = 10'd220; pipe_r = 10'd281;
    do_tick();
    checks++; if (q_play !== 1'b1) begin failures++; $display("FAIL ground_edge: q_play=%b expected 1", q_play); end
    bird_y = 10'd441;
    do_tick();
    checks++; if (q_dead !== 1'b1 || stop !== 1'b1) begin failures++; $display("FAIL ground_dead: q_dead=%b stop=%b expected 1/1", q_dead, stop); end
    checks++; if (hit_ground !== 1'b1) begin failures++; $display("FAIL ground_cause: hit_ground=%b expected 1", hit_ground); end
    safe_inputs();
    ack_seen = 1'b0;
    repeat (30) do_tick();
    flap_btn = 1'b1;
    @(negedge clk);
    if (ack) ack_seen = 1'b1;
    for (int i = 0; i < 35; i++) begin
      do_tick();
      if (ack) ack_seen = 1'b1;
    end
    checks++; if (ack_seen !== 1'b0 || q_dead !== 1'b1) begin failures++; $display("FAIL early_flap: ack_seen=%b q_dead=%b expected 0/1", ack_seen, q_dead); end
    flap_btn = 1'b0;
    @(negedge clk);
    flap_btn = 1'b1;
    @(negedge clk);
    checks++; if (ack !== 1'b1 || q_idle !== 1'b1 || stop !== 1'b0) begin failures++; $display("FAIL late_flap: ack=%b q_idle=%b stop=%b expected 1/1/0", ack, q_idle, stop); end
    flap_btn = 1'b0;
    @(negedge clk);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL late_ack_width: ack=%b expected 0", ack); end
  endtask

`ifdef COLLISION_COIN_EN
  task automatic test_coin();
    int pulses;
    begin_game();
    coin_l = 10'd210; coin_r = 10'd225; coin_top = 10'd205; coin_bot = 10'd215; coin_idx = 3'd3;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      do_tick();
      if (coin_taken) pulses++;
    end
    checks++; if (pulses != 1 || coin_count !== 8'd1) begin failures++; $display("FAIL coin_once: pulses=%0d count=%0d expected 1/1", pulses, coin_count); end
    coin_l = 10'd600; coin_r = 10'd620;
    coin_idx = 3'd4; do_tick();
    coin_idx = 3'd0; do_tick();
    coin_l = 10'd210; coin_r = 10'd225; coin_idx = 3'd3;
    do_tick();
    checks++; if (coin_taken !== 1'b1 || coin_count !== 8'd2) begin failures++; $display("FAIL coin_recycle: taken=%b count=%0d expected 1/2", coin_taken, coin_count); end
    bird_y = 10'd441; coin_top = 10'd445; coin_bot = 10'd455; coin_idx = 3'd1;
    do_tick();
    checks++; if (q_dead !== 1'b1 || coin_taken !== 1'b0 || coin_count !== 8'd2) begin failures++; $display("FAIL death_coin: q_dead=%b taken=%b count=%0d expected 1/0/2", q_dead, coin_taken, coin_count); end
    pulse_reset();
  endtask

  task automatic test_coin_saturate();
    begin_game();
    coin_l = 10'd210; coin_r = 10'd225; coin_top = 10'd205; coin_bot = 10'd215;
    for (int i = 0; i < 256; i++) begin
      coin_idx = 3'(i % 2);
      do_tick();
      if (i == 253) begin
        checks++; if (coin_count !== 8'd254) begin failures++; $display("FAIL sat_254: count=%0d expected 254", coin_count); end
      end
    end
    checks++; if (coin_count !== 8'd255) begin failures++; $display("FAIL sat_255: count=%0d expected 255", coin_count); end
    pulse_reset();
  endtask
`else
  task automatic test_coin_disabled();
    bit taken_seen;
    begin_game();
    coin_l = 10'd210; coin_r = 10'd225; coin_top = 10'd205; coin_bot = 10'd215;
    taken_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      coin_idx = 3'(i % 5);
      do_tick();
      if (coin_taken) taken_seen = 1'b1;
    end
    checks++; if (taken_seen !== 1'b0 || coin_count !== 8'd0) begin failures++; $display("FAIL coin_disabled: taken=%b count=%0d expected 0/0", taken_seen, coin_count); end
    pulse_reset();
  endtask
`endif

  task automatic test_reset_mid();
    bit ack_seen;
    begin_game();
    coin_l = 10'd210; coin_r = 10'd225; coin_top = 10'd205; coin_bot = 10'd215;
    for (int i = 0; i < 7; i++) begin
      coin_idx = 3'(i % 2);
      do_tick();
    end
`ifdef COLLISION_COIN_EN
    checks++; if (coin_count !== 8'd7) begin failures++; $display("FAIL pre_reset_count: count=%0d expected 7", coin_count); end
`endif
    #2 reset = 1'b1;
    #1;
    checks++;
    if (q_idle !== 1'b1 || q_play !== 1'b0 || coin_count !== 8'd0 || ack !== 1'b0 || stop !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: q_idle=%b q_play=%b count=%0d ack=%b stop=%b expected 1/0/0/0/0", q_idle, q_play, coin_count, ack, stop);
    end
    @(negedge clk);
    reset = 1'b0;
    safe_inputs();
    ack_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ack) ack_seen = 1'b1;
    end
    checks++; if (ack_seen !== 1'b0 || q_idle !== 1'b1) begin failures++; $display("FAIL reset_no_ack: ack_seen=%b q_idle=%b expected 0/1", ack_seen, q_idle); end
  endtask

  task automatic test_random_play();
    int run, bottom, ty, tpl, tpr, tgt, tgb;
    bit dead, hg, horiz, pov;
    for (int g = 0; g < 12; g++) begin
      safe_inputs();
      begin_game();
      run = 0; dead = 1'b0; hg = 1'b0;
      for (int t = 0; t < 40 && !dead; t++) begin
        repeat ($urandom_range(0, 2)) begin
          bird_y = 10'($urandom_range(0, 700)); pipe_l = 10'($urandom_range(0, 300));
          pipe_r = 10'($urandom_range(200, 700)); gap_top = 10'($urandom_range(0, 500));
          gap_bot = 10'($urandom_range(0, 500));
          @(negedge clk);
        end
        ty  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(430, 460)) : int'($urandom_range(40, 400));
        tpl = $urandom_range(100, 320);
        tpr = tpl + int'($urandom_range(20, 80));
        tgt = $urandom_range(60, 250);
        tgb = tgt + int'($urandom_range(60, 140));
        bird_y = 10'(ty); pipe_l = 10'(tpl); pipe_r = 10'(tpr); gap_top = 10'(tgt); gap_bot = 10'(tgb);
        do_tick();
        bottom = ty + 20;
        horiz  = (tpl < 230) && (tpr > 200);
        pov    = horiz && ((ty < tgt) || (bottom > tgb));
        run    = pov ? run + 1 : 0;
        if (bottom >= 460) begin dead = 1'b1; hg = 1'b1; end
        else if (run >= HIT) begin dead = 1'b1; hg = 1'b0; end
        checks++;
        if (q_dead !== dead || stop !== dead || (dead && hit_ground !== hg)) begin
          failures++;
          $display("FAIL random_tick g=%0d t=%0d: q_dead=%b stop=%b hit_ground=%b expected %b/%b/%b", g, t, q_dead, stop, hit_ground, dead, dead, hg);
        end
        checks++; if (coin_count !== 8'd0) begin failures++; $display("FAIL random_count: count=%0d expected 0", coin_count); end
      end
      safe_inputs();
      if (dead && (g % 2 == 0)) finish_dead();
      else pulse_reset();
    end
  endtask

  initial begin
    safe_inputs();
    @(negedge clk);
    test_reset();
    test_start();
    test_pipe_hit();
    test_ground_and_ack();
`ifdef COLLISION_COIN_EN
    test_coin();
    test_coin_saturate();
`else
    test_coin_disabled();
`endif
    test_reset_mid();
    test_random_play();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
